bid_master_port: RTL

Per-master front-end that sits directly upstream of the four-master bidding arbiter, one instance per master port. It queues host commands (address, read/write, write data, bid) in a small FIFO. It presents the head command to the arbiter as a bid, holds it until granted, and returns read data to the host. Bids that go ungranted are aged upward so a low bidder cannot starve indefinitely.

---
 rtl/bid_pkg.sv | 49 ++++
 rtl/bid_master_port_if.sv | 37 +++
 rtl/bid_fifo.sv | 55 +++++
 rtl/bid_master_port.sv | 118 +++++++++++
 4 files changed

// File: rtl/bid_pkg.sv
// Shared types and constants for the per-master bidding front-end.
// Holds the FSM states, the bid range, the command record and the slave address map.
package bid_pkg;

  localparam int unsigned BID_W = 4;
  localparam logic [BID_W-1:0] BID_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE,
    BID,
    RECOVER
  } state_t;

  typedef struct packed {
    logic [31:0]      addr;
    logic             rw;
    logic [31:0]      wdata;
    logic [BID_W-1:0] bid;
  } bid_cmd_t;

  localparam logic [31:0] SLAVE0_BASE = 32'hFFEF_0200;
  localparam logic [31:0] SLAVE1_BASE = 32'hFFEF_1200;
  localparam logic [31:0] SLAVE2_BASE = 32'hFFEF_2200;
  localparam logic [31:0] SLAVE3_BASE = 32'hFFEF_3200;

  localparam logic [31:0] MASTER0_OFFSET = 32'h00;
  localparam logic [31:0] MASTER1_OFFSET = 32'h10;
  localparam logic [31:0] MASTER2_OFFSET = 32'h20;
  localparam logic [31:0] MASTER3_OFFSET = 32'h30;

  function automatic logic [31:0] slave_addr(input logic [1:0] slave, input logic [1:0] master);
    logic [31:0] base;
    logic [31:0] offset;
    case (slave)
      2'd0:    base = SLAVE0_BASE;
      2'd1:    base = SLAVE1_BASE;
      2'd2:    base = SLAVE2_BASE;
      default: base = SLAVE3_BASE;
    endcase
    case (master)
      2'd0:    offset = MASTER0_OFFSET;
      2'd1:    offset = MASTER1_OFFSET;
      2'd2:    offset = MASTER2_OFFSET;
      default: offset = MASTER3_OFFSET;
    endcase
    return base + offset;
  endfunction

endpackage

// File: rtl/bid_master_port_if.sv
// Host command/response and arbiter-facing signals of one master port.
// The master modport is the port logic itself; slave is the host/arbiter side.
interface bid_master_port_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  import bid_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rw;
  logic [DATA_W-1:0] cmd_wdata;
  logic [BID_W-1:0]  cmd_bid;

  logic              rsp_valid;
  logic              rsp_rw;
  logic [DATA_W-1:0] rsp_rdata;

  logic [BID_W-1:0]  req;
  logic              grant;
  logic [ADDR_W-1:0] addr;
  logic              RW;
  logic [DATA_W-1:0] DataToSlave;
  logic [DATA_W-1:0] DataFromSlave;

  modport master (
    input  cmd_valid, cmd_addr, cmd_rw, cmd_wdata, cmd_bid, grant, DataFromSlave,
    output cmd_ready, rsp_valid, rsp_rw, rsp_rdata, req, addr, RW, DataToSlave
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_rw, cmd_wdata, cmd_bid, grant, DataFromSlave,
    input  cmd_ready, rsp_valid, rsp_rw, rsp_rdata, req, addr, RW, DataToSlave
  );

endinterface

// File: rtl/bid_fifo.sv
// Synchronous command FIFO with a registered head view.
// A push while full is taken only when a pop frees the slot in the same edge.
module bid_fifo
  import bid_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = bid_cmd_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  T                 din,
  output T                 head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bid_master_port.sv
// Per-master front-end: queues host commands, bids the head to the arbiter,
// ages ungranted bids upward and returns a one-cycle response per transfer.
module bid_master_port
  import bid_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AGE_LIMIT = 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input logic              clk,
  input logic              rst,
  bid_master_port_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AGE_W = (AGE_LIMIT > 1) ? $clog2(AGE_LIMIT) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wdata;
    logic [BID_W-1:0]  bid;
  } cmd_t;

  state_t           state;
  state_t           next_state;
  cmd_t             din;
  cmd_t             head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             accept;
  logic             pop;
  logic             bidding;
  logic             entering_bid;
  logic [BID_W-1:0] eff_bid;
  logic [AGE_W-1:0] age;

  assign din = '{addr: bus.cmd_addr, rw: bus.cmd_rw, wdata: bus.cmd_wdata, bid: bus.cmd_bid};

  assign bus.cmd_ready = (count != CNT_W'(DEPTH));
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign bidding       = (state == BID);
  assign pop           = bidding && bus.grant;
  assign entering_bid  = !bidding && (next_state == BID);

  bid_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!empty) next_state = BID;
      BID:     if (bus.grant) next_state = RECOVER;
      RECOVER: next_state = empty ? IDLE : BID;
      default: next_state = IDLE;
    endcase
  end

  // Bid 0 is not a valid request, so a fresh head always bids at least 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eff_bid <= '0;
      age     <= '0;
    end else if (entering_bid) begin
      eff_bid <= (head.bid == '0) ? BID_W'(1) : head.bid;
      age     <= '0;
    end else if (bidding && !bus.grant) begin
      if (age == AGE_W'(AGE_LIMIT - 1)) begin
        age     <= '0;
        eff_bid <= (eff_bid == BID_MAX) ? BID_MAX : eff_bid + BID_W'(1);
      end else begin
        age <= age + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rw    <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= pop;
      if (pop) begin
        bus.rsp_rw    <= head.rw;
        bus.rsp_rdata <= head.rw ? '0 : bus.DataFromSlave;
      end
    end
  end

  assign bus.req         = bidding ? eff_bid    : '0;
  assign bus.addr        = bidding ? head.addr  : '0;
  assign bus.RW          = bidding ? head.rw    : 1'b0;
  assign bus.DataToSlave = bidding ? head.wdata : '0;

  logic unused_full;
  assign unused_full = full;

endmodule
